// File: rtl/parking_sensor_frontend.sv
// Sensor front end for the parking occupancy FSM: sync/debounce, request queuing, vacate FIFO, arbiter.
// Optional saturating event statistics are enabled by defining PARKING_FE_STATS_EN.
module parking_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PENDING_MAX     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_raw,
  input  logic       exit_raw,
  input  logic [3:0] slot_raw,
  input  logic       full_light,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       event_drop,
  output logic [1:0] entry_pending,
  output logic [1:0] exit_pending
`ifdef PARKING_FE_STATS_EN
  ,
  output logic [7:0] stat_entries,
  output logic [7:0] stat_exits,
  output logic [7:0] stat_drops
`endif
);

  localparam int         NB    = 6;
  localparam int         CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [1:0] PMAX  = 2'(PENDING_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE_EN, ISSUE_EX, GAP} state_e;

  function automatic logic [1:0] pend_next(input logic [1:0] cur, input logic inc,
                                           input logic dec);
    logic [1:0] res;
    res = cur;
    if (inc && !dec && (cur != PMAX)) res = cur + 2'd1;
    else if (dec && !inc)             res = cur - 2'd1;
    return res;
  endfunction

  logic [NB-1:0]    raw_w;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    lvl_q, lvl_d, prev_q;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];

  logic       entry_rise_w, exit_rise_w;
  logic [3:0] slot_fall_w;

  logic [3:0] vac_mask_q, vac_mask_d, vac_all_w, vac_sel_w;
  logic [1:0] vac_idx_w;
  logic       vac_push_w;

  logic [1:0] fifo_mem_q [4];
  logic [1:0] fifo_wr_q, fifo_rd_q, fifo_head_w;
  logic [2:0] fifo_cnt_q;
  logic       fifo_full_w, fifo_push_w, fifo_drop_w;

  logic [1:0] entry_pend_q, exit_pend_q;
  logic       en_drop_w, ex_drop_w, event_drop_q;

  state_e     state_q;
  logic       last_ex_q;
  logic       can_issue_w, en_elig_w, ex_elig_w, launch_en_w, launch_ex_w;
  logic       entry_sensor_q, exit_sensor_q;
  logic [1:0] exit_loc_q;

  assign raw_w = {slot_raw, exit_raw, entry_raw};

  // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = sync2_q[i];
        else                                            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign entry_rise_w = lvl_q[0] & ~prev_q[0];
  assign exit_rise_w  = lvl_q[1] & ~prev_q[1];
  assign slot_fall_w  = prev_q[5:2] & ~lvl_q[5:2];

  // Fresh falls merge with leftovers so a single fall reaches the FIFO in the cycle it is seen.
  assign vac_all_w  = vac_mask_q | slot_fall_w;
  assign vac_push_w = |vac_all_w;

  always_comb begin
    vac_idx_w = 2'd0;
    vac_sel_w = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (vac_all_w[i]) begin
        vac_idx_w = 2'(i);
        vac_sel_w = 4'b0001 << i;
      end
    end
    vac_mask_d = vac_all_w & ~vac_sel_w;
  end

  assign fifo_full_w = (fifo_cnt_q == 3'd4);
  assign fifo_push_w = vac_push_w && (!fifo_full_w || launch_ex_w);
  assign fifo_drop_w = vac_push_w && fifo_full_w && !launch_ex_w;
  assign fifo_head_w = fifo_mem_q[fifo_rd_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vac_mask_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
    end else begin
      vac_mask_q <= vac_mask_d;
      if (fifo_push_w) begin
        fifo_mem_q[fifo_wr_q] <= vac_idx_w;
        fifo_wr_q             <= fifo_wr_q + 2'd1;
      end
      if (launch_ex_w) fifo_rd_q <= fifo_rd_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + {2'b00, fifo_push_w} - {2'b00, launch_ex_w};
    end
  end

  assign en_drop_w = entry_rise_w && !launch_en_w && (entry_pend_q == PMAX);
  assign ex_drop_w = exit_rise_w && !launch_ex_w && (exit_pend_q == PMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_pend_q <= '0;
      exit_pend_q  <= '0;
      event_drop_q <= 1'b0;
    end else begin
      entry_pend_q <= pend_next(entry_pend_q, entry_rise_w, launch_en_w);
      exit_pend_q  <= pend_next(exit_pend_q, exit_rise_w, launch_ex_w);
      event_drop_q <= en_drop_w | ex_drop_w | fifo_drop_w;
    end
  end

  // GAP arbitrates like IDLE, so back-to-back pulses are exactly two cycles apart.
  assign can_issue_w = (state_q == IDLE) || (state_q == GAP);
  assign en_elig_w   = (entry_pend_q != 2'd0) && !full_light;
  assign ex_elig_w   = (exit_pend_q != 2'd0) && (fifo_cnt_q != 3'd0);
  assign launch_en_w = can_issue_w && en_elig_w && (!ex_elig_w || last_ex_q);
  assign launch_ex_w = can_issue_w && ex_elig_w && (!en_elig_w || !last_ex_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_ex_q      <= 1'b1;
      entry_sensor_q <= 1'b0;
      exit_sensor_q  <= 1'b0;
      exit_loc_q     <= 2'b00;
    end else begin
      entry_sensor_q <= 1'b0;
      exit_sensor_q  <= 1'b0;
      exit_loc_q     <= 2'b00;
      case (state_q)
        IDLE, GAP: begin
          if (launch_en_w) begin
            state_q        <= ISSUE_EN;
            entry_sensor_q <= 1'b1;
            last_ex_q      <= 1'b0;
          end else if (launch_ex_w) begin
            state_q       <= ISSUE_EX;
            exit_sensor_q <= 1'b1;
            exit_loc_q    <= fifo_head_w;
            last_ex_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= GAP;
      endcase
    end
  end

  assign entry_sensor  = entry_sensor_q;
  assign exit_sensor   = exit_sensor_q;
  assign exit_location = exit_loc_q;
  assign event_drop    = event_drop_q;
  assign entry_pending = entry_pend_q;
  assign exit_pending  = exit_pend_q;

`ifdef PARKING_FE_STATS_EN
  logic [7:0] stat_en_q, stat_ex_q, stat_drop_q;
  logic       drop_d;

  assign drop_d = en_drop_w | ex_drop_w | fifo_drop_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_en_q   <= '0;
      stat_ex_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (launch_en_w && (stat_en_q != 8'hFF))  stat_en_q   <= stat_en_q + 8'd1;
      if (launch_ex_w && (stat_ex_q != 8'hFF))  stat_ex_q   <= stat_ex_q + 8'd1;
      if (drop_d && (stat_drop_q != 8'hFF))     stat_drop_q <= stat_drop_q + 8'd1;
    end
  end

  assign stat_entries = stat_en_q;
  assign stat_exits   = stat_ex_q;
  assign stat_drops   = stat_drop_q;
`endif

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Bench for parking_sensor_frontend: directed scenarios plus randomized sensor traffic,
// all outputs compared every cycle against a behavioural model.
module tb_parking_sensor_frontend;

  localparam int D    = 4;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       entry_raw, exit_raw, full_light;
  logic [3:0] slot_raw;
  logic       entry_sensor, exit_sensor, event_drop;
  logic [1:0] exit_location, entry_pending, exit_pending;
`ifdef PARKING_FE_STATS_EN
  logic [7:0] stat_entries, stat_exits, stat_drops;
`endif

  int n_checks = 0;
  int n_errors = 0;

  parking_sensor_frontend #(.DEBOUNCE_CYCLES(D), .PENDING_MAX(PMAX)) dut (
    .clk(clk), .reset_n(reset_n), .entry_raw(entry_raw), .exit_raw(exit_raw),
    .slot_raw(slot_raw), .full_light(full_light), .entry_sensor(entry_sensor),
    .exit_sensor(exit_sensor), .exit_location(exit_location), .event_drop(event_drop),
    .entry_pending(entry_pending), .exit_pending(exit_pending)
`ifdef PARKING_FE_STATS_EN
    , .stat_entries(stat_entries), .stat_exits(stat_exits), .stat_drops(stat_drops)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state: what each output should read after the latest clock edge.
  logic [5:0] hist[$];
  logic [5:0] m_lvl, m_lvl_prev;
  logic [3:0] m_vmask;
  int         fifo[$];
  int         m_en_pend, m_ex_pend, m_cyc, m_last_issue;
  bit         m_last_was_exit;
  logic       m_en_s, m_ex_s, m_drop;
  logic [1:0] m_loc;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(6'd0);
    fifo.delete();
    m_lvl = '0; m_lvl_prev = '0; m_vmask = '0;
    m_en_pend = 0; m_ex_pend = 0; m_cyc = 0; m_last_issue = -10;
    m_last_was_exit = 1'b1;
    m_en_s = 1'b0; m_ex_s = 1'b0; m_drop = 1'b0; m_loc = 2'b00;
  endtask

  task automatic model_step();
    logic [5:0] rise, fall, newlvl;
    bit en_el, ex_el, go_en, go_ex, drop, all_same;
    int n, lo;
    m_cyc++;
    en_el = (m_en_pend > 0) && !full_light;
    ex_el = (m_ex_pend > 0) && (fifo.size() > 0);
    go_en = 0; go_ex = 0;
    if (m_cyc - m_last_issue >= 2) begin
      if (en_el && ex_el) begin
        if (m_last_was_exit) go_en = 1; else go_ex = 1;
      end else if (en_el) go_en = 1;
      else if (ex_el) go_ex = 1;
    end
    m_en_s = go_en; m_ex_s = go_ex; m_loc = 2'b00;
    if (go_en || go_ex) begin m_last_issue = m_cyc; m_last_was_exit = go_ex; end
    if (go_ex) m_loc = 2'(fifo.pop_front());
    rise = m_lvl & ~m_lvl_prev;
    fall = ~m_lvl & m_lvl_prev;
    drop = 0;
    m_en_pend = m_en_pend + int'(rise[0]) - int'(go_en);
    if (m_en_pend > PMAX) begin m_en_pend = PMAX; drop = 1; end
    m_ex_pend = m_ex_pend + int'(rise[1]) - int'(go_ex);
    if (m_ex_pend > PMAX) begin m_ex_pend = PMAX; drop = 1; end
    m_vmask = m_vmask | fall[5:2];
    if (m_vmask != 0) begin
      lo = 0;
      while (!m_vmask[lo]) lo++;
      m_vmask[lo] = 1'b0;
      if (fifo.size() < 4) fifo.push_back(lo); else drop = 1;
    end
    m_drop = drop;
    // A level is accepted once the D samples before the newest synchroniser stage agree.
    newlvl = m_lvl;
    n = hist.size();
    for (int b = 0; b < 6; b++) begin
      all_same = 1;
      for (int k = n - 1 - D; k <= n - 2; k++)
        if (hist[k][b] != hist[n - 2][b]) all_same = 0;
      if (all_same) newlvl[b] = hist[n - 2][b];
    end
    m_lvl_prev = m_lvl;
    m_lvl = newlvl;
    hist.push_back({slot_raw, exit_raw, entry_raw});
    if (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("entry_sensor", 32'(entry_sensor), 32'(m_en_s));
    chk("exit_sensor", 32'(exit_sensor), 32'(m_ex_s));
    chk("exit_location", 32'(exit_location), 32'(m_loc));
    chk("event_drop", 32'(event_drop), 32'(m_drop));
    chk("entry_pending", 32'(entry_pending), 32'(m_en_pend));
    chk("exit_pending", 32'(exit_pending), 32'(m_ex_pend));
    if (entry_sensor === 1'b1 && exit_sensor === 1'b1) chk("both_pulses", 32'd1, 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [3:0] slots);
    @(negedge clk);
    reset_n = 1'b0; entry_raw = 0; exit_raw = 0; full_light = 0; slot_raw = slots;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_entry_sensor", 32'(entry_sensor), 0);
      chk("rst_exit_sensor", 32'(exit_sensor), 0);
      chk("rst_drop", 32'(event_drop), 0);
      chk("rst_pend", 32'({entry_pending, exit_pending, exit_location}), 0);
    end
    reset_n = 1'b1;
  endtask

  task automatic wait_pulse(input bit want_exit, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((want_exit ? exit_sensor : entry_sensor) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int lat, pulses, drops, en_t, ex_t;
  int times[$];
  int hold[6];

  initial begin
    reset_n = 1'b0; entry_raw = 0; exit_raw = 0; full_light = 0; slot_raw = 4'b0000;

    // T1: latency of a clean entry edge
    do_reset(4'b0000);
    steps(3);
    entry_raw = 1'b1;
    wait_pulse(1'b0, 20, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    step();
    chk("t1_single_pulse", 32'(entry_sensor), 0);
    chk("t1_pending_zero", 32'(entry_pending), 0);
    entry_raw = 1'b0;
    steps(10);

    // T2: glitch shorter than the debounce window
    do_reset(4'b0000);
    steps(2);
    entry_raw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) entry_raw = 1'b0;
      step();
      pulses += int'(entry_sensor === 1'b1) + int'(entry_pending !== 2'd0);
    end
    chk("t2_glitch_ignored", 32'(pulses), 0);

    // T3: vacate then exit, and exit before any vacate
    do_reset(4'b0110);
    steps(10);
    slot_raw = 4'b0100;
    steps(10);
    exit_raw = 1'b1;
    wait_pulse(1'b1, 20, lat);
    chk("t3_found", 32'(lat > 0), 1);
    chk("t3_location", 32'(exit_location), 32'd1);
    exit_raw = 1'b0;
    steps(8);
    exit_raw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      if (i == 7) exit_raw = 1'b0;
      step();
      pulses += int'(exit_sensor === 1'b1);
    end
    chk("t3_no_early_exit", 32'(pulses), 0);
    chk("t3_exit_waiting", 32'(exit_pending), 32'd1);
    slot_raw = 4'b0000;
    wait_pulse(1'b1, 20, lat);
    chk("t3_late_location", 32'(exit_location), 32'd2);
    steps(3);
    chk("t3_exit_cleared", 32'(exit_pending), 0);

    // T4: entry and exit eligible together right after reset
    do_reset(4'b0001);
    steps(12);
    slot_raw = 4'b0000; entry_raw = 1'b1; exit_raw = 1'b1;
    en_t = -1; ex_t = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (entry_sensor === 1'b1 && en_t < 0) en_t = i;
      if (exit_sensor === 1'b1 && ex_t < 0) ex_t = i;
    end
    chk("t4_entry_latency", 32'(en_t), 32'd8);
    chk("t4_exit_after_gap", 32'(ex_t - en_t), 32'd2);
    entry_raw = 1'b0; exit_raw = 1'b0;
    steps(8);

    // T5: full_light holds entries, saturation drops the fourth
    do_reset(4'b0000);
    full_light = 1'b1;
    drops = 0;
    for (int e = 0; e < 4; e++) begin
      entry_raw = 1'b1;
      for (int i = 0; i < 7; i++) begin step(); drops += int'(event_drop === 1'b1); end
      entry_raw = 1'b0;
      for (int i = 0; i < 7; i++) begin step(); drops += int'(event_drop === 1'b1); end
    end
    steps(3);
    chk("t5_drops", 32'(drops), 32'd1);
    chk("t5_pending_sat", 32'(entry_pending), 32'd3);
    full_light = 1'b0;
    times.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      if (entry_sensor === 1'b1) times.push_back(i);
    end
    chk("t5_pulse_count", 32'(times.size()), 32'd3);
    for (int i = 1; i < times.size(); i++) chk("t5_spacing", 32'(times[i] - times[i-1]), 32'd2);

    // T6: reset asserted in the middle of an exit pulse
    do_reset(4'b0011);
    steps(10);
    slot_raw = 4'b0000; exit_raw = 1'b1;
    wait_pulse(1'b1, 20, lat);
    chk("t6_pulse_seen", 32'(exit_sensor), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_clear", 32'(exit_sensor), 0);
    chk("t6_pending_clear", 32'({entry_pending, exit_pending}), 0);
    exit_raw = 1'b0;
    steps(2);
    @(negedge clk);
    reset_n = 1'b1;
    steps(4);
    chk("t6_pending_after", 32'({entry_pending, exit_pending}), 0);
    exit_raw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin step(); pulses += int'(exit_sensor === 1'b1); end
    chk("t6_fifo_empty", 32'(pulses), 0);
    chk("t6_exit_waits", 32'(exit_pending), 32'd1);

    // Randomized traffic against the model
    do_reset(4'b0000);
    for (int b = 0; b < 6; b++) hold[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if (hold[b] == 0) begin
          logic v;
          v = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 14));
          if (b == 0) entry_raw = v;
          else if (b == 1) exit_raw = v;
          else slot_raw[b-2] = v;
        end else begin
          hold[b]--;
        end
      end
      if ($urandom_range(0, 15) == 0) full_light = ($urandom_range(0, 3) == 0);
      if (c == 2000) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
